pipeline_mem_responder: RTL and testbench
=========================================

Name: pipeline_mem_responder

Overview:
Memory-side responder for the core's instruction-fetch and data ports. It accepts word requests from the pipeline over a valid/ready handshake and returns read data or write acknowledges after a fixed latency. Instruction and data ports are independent and served from one shared word array. The block is the memory model used in simulation and is synthesizable as an on-chip RAM for small builds.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
ADDR_BITS, 10, log2(DEPTH_WORDS).
LATENCY, 2, cycles from request acceptance to response. Legal values are 1 to 15.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
inst_req_valid  in  1  fetch request present.
inst_req_ready  out  1  fetch port can accept a request.
inst_addr  in  32  byte address of the fetch.
inst_resp_valid  out  1  one-cycle pulse; inst_data and inst_err are valid.
inst_data  out  32  fetched word.
inst_err  out  1  fetch was misaligned or out of range.
data_req_valid  in  1  load/store request present.
data_req_ready  out  1  data port can accept a request.
data_addr  in  32  byte address.
data_we  in  1  1 = store, 0 = load.
data_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i].
data_wdata  in  32  store data.
data_resp_valid  out  1  one-cycle pulse; data_rdata and data_err are valid.
data_rdata  out  32  load data; 0 for stores.
data_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset is asynchronous. While reset is high:
  - all outputs are 0, except both req_ready signals, which are 1 once reset deasserts;
  - both port FSMs go to IDLE;
  - in-flight requests are dropped with no response;
  - array contents are not cleared.
- Each port has its own FSM with states IDLE, WAIT and RESP.
  - IDLE: req_ready=1. If req_valid=1 at a rising edge, the request is accepted. Next state is RESP if LATENCY=1, otherwise WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. The counter decrements each cycle. When it reaches 1, next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle, and req_ready=0. Next state is always IDLE.
- Only one request is outstanding per port. Back-to-back accepts are spaced LATENCY+1 cycles apart.
- Responses cannot be back-pressured.
- Address checks are performed at acceptance:
  - misaligned means addr[1:0]!=0;
  - out of range means addr[31:ADDR_BITS+2]!=0;
  - either condition sets err=1 in the response, read data is 0, and a store is suppressed.
- Word index is addr[ADDR_BITS+1:2].
- Read data is captured into a port-local holding register at the acceptance edge. It is held unchanged until the response cycle and driven only during RESP; outside RESP, data outputs are 0.
- Stores:
  - the write commits at the acceptance edge, only for byte lanes with data_be[i]=1;
  - data_be=0 is a legal no-op store and still produces a response;
  - the response carries data_rdata=0 and data_err per the address check.
- Same-edge collisions:
  - a fetch accepted on the same edge as a store to the same word returns the old word (read-before-write);
  - a load following a store returns the new data.
- Input signals other than req_valid are don't-care when req_valid=0.
- If req_valid is held high during WAIT or RESP, the request is not accepted until the port returns to IDLE. The requester must hold valid and payload stable until it is accepted.
- Reset asserted mid-WAIT aborts the transaction. A store already committed at acceptance remains in the array.

Test Plan:
- Preload word 4 with 0x00000013. Fetch inst_addr=0x10 with LATENCY=2 -> inst_resp_valid pulses exactly 2 cycles after accept, inst_data=0x00000013, inst_err=0. inst_req_ready is low for those 2 cycles.
- Store 0xDEADBEEF to 0x20 with data_be=4'b0101, over old word 0x11223344. Then load 0x20 -> data_rdata=0x11AD33EF, data_err=0. The store response has data_rdata=0.
- Misaligned load 0x22 -> data_err=1, data_rdata=0. Out-of-range store to (DEPTH_WORDS*4) -> data_err=1, and a following load of 0x0 shows unchanged contents.
- Fetch and store to 0x30 accepted on the same edge, old word 0xAAAAAAAA, new 0x55555555 with be=4'hF -> inst_data=0xAAAAAAAA. A later fetch of 0x30 returns 0x55555555.
- Hold inst_req_valid high continuously with incrementing addresses 0x0, 0x4, 0x8 -> accepts occur every LATENCY+1 cycles, one response per accept, in order, with no duplicates.
- Assert reset during WAIT of a load -> no data_resp_valid is produced. After release, data_req_ready=1 in the first cycle and a new load completes normally.

Source files
------------

// File: rtl/pipeline_mem_responder.sv
// Memory-side responder for the instruction-fetch and data ports: one shared word array,
// one outstanding request per port, and a fixed response latency on each port.
module pipeline_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    input  logic [31:0] inst_addr,
    output logic        inst_resp_valid,
    output logic [31:0] inst_data,
    output logic        inst_err,

    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic [31:0] data_addr,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_resp_valid,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] r_mem [DEPTH_WORDS];

    state_t      r_inst_state, w_inst_state_next;
    logic [3:0]  r_inst_cnt, w_inst_cnt_next;
    logic [31:0] r_inst_hold;
    logic        r_inst_err;

    state_t      r_data_state, w_data_state_next;
    logic [3:0]  r_data_cnt, w_data_cnt_next;
    logic [31:0] r_data_hold;
    logic        r_data_err;

    logic                 w_inst_accept, w_inst_bad;
    logic                 w_data_accept, w_data_bad;
    logic [ADDR_BITS-1:0] w_inst_idx, w_data_idx;

    assign w_inst_bad    = (inst_addr[1:0] != 2'b00) || (inst_addr[31:ADDR_BITS+2] != '0);
    assign w_data_bad    = (data_addr[1:0] != 2'b00) || (data_addr[31:ADDR_BITS+2] != '0);
    assign w_inst_idx    = inst_addr[ADDR_BITS+1:2];
    assign w_data_idx    = data_addr[ADDR_BITS+1:2];
    assign w_inst_accept = inst_req_valid && inst_req_ready;
    assign w_data_accept = data_req_valid && data_req_ready;

    // Fetch port FSM. Ready is masked by reset so it only rises once reset deasserts.
    always_comb begin
        w_inst_state_next = r_inst_state;
        w_inst_cnt_next   = r_inst_cnt;
        inst_req_ready    = 1'b0;
        inst_resp_valid   = 1'b0;
        case (r_inst_state)
            IDLE: begin
                inst_req_ready = !reset;
                if (inst_req_valid && !reset) begin
                    if (LATENCY == 1) begin
                        w_inst_state_next = RESP;
                    end else begin
                        w_inst_state_next = WAIT;
                        w_inst_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_inst_cnt == 4'd1) begin
                    w_inst_state_next = RESP;
                end else begin
                    w_inst_cnt_next = r_inst_cnt - 4'd1;
                end
            end
            RESP: begin
                inst_resp_valid   = 1'b1;
                w_inst_state_next = IDLE;
            end
            default: w_inst_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inst_state <= IDLE;
            r_inst_cnt   <= '0;
            r_inst_hold  <= '0;
            r_inst_err   <= 1'b0;
        end else begin
            r_inst_state <= w_inst_state_next;
            r_inst_cnt   <= w_inst_cnt_next;
            if (w_inst_accept) begin
                // Non-blocking read sees the pre-store word on a same-edge collision.
                r_inst_hold <= w_inst_bad ? '0 : r_mem[w_inst_idx];
                r_inst_err  <= w_inst_bad;
            end
        end
    end

    // Data port FSM.
    always_comb begin
        w_data_state_next = r_data_state;
        w_data_cnt_next   = r_data_cnt;
        data_req_ready    = 1'b0;
        data_resp_valid   = 1'b0;
        case (r_data_state)
            IDLE: begin
                data_req_ready = !reset;
                if (data_req_valid && !reset) begin
                    if (LATENCY == 1) begin
                        w_data_state_next = RESP;
                    end else begin
                        w_data_state_next = WAIT;
                        w_data_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_data_cnt == 4'd1) begin
                    w_data_state_next = RESP;
                end else begin
                    w_data_cnt_next = r_data_cnt - 4'd1;
                end
            end
            RESP: begin
                data_resp_valid   = 1'b1;
                w_data_state_next = IDLE;
            end
            default: w_data_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_state <= IDLE;
            r_data_cnt   <= '0;
            r_data_hold  <= '0;
            r_data_err   <= 1'b0;
        end else begin
            r_data_state <= w_data_state_next;
            r_data_cnt   <= w_data_cnt_next;
            if (w_data_accept) begin
                r_data_hold <= (w_data_bad || data_we) ? '0 : r_mem[w_data_idx];
                r_data_err  <= w_data_bad;
            end
        end
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_data_accept && data_we && !w_data_bad) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_be[i]) begin
                    r_mem[w_data_idx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    assign inst_data  = inst_resp_valid ? r_inst_hold : '0;
    assign inst_err   = inst_resp_valid && r_inst_err;
    assign data_rdata = data_resp_valid ? r_data_hold : '0;
    assign data_err   = data_resp_valid && r_data_err;

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Bench for pipeline_mem_responder: cycle-stamped reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic on both ports.
module tb_pipeline_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int AB    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_valid = 1'b0;
    logic        inst_req_ready;
    logic [31:0] inst_addr = '0;
    logic        inst_resp_valid;
    logic [31:0] inst_data;
    logic        inst_err;
    logic        data_req_valid = 1'b0;
    logic        data_req_ready;
    logic [31:0] data_addr = '0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_wdata = '0;
    logic        data_resp_valid;
    logic [31:0] data_rdata;
    logic        data_err;

    always #5 clk = ~clk;

    pipeline_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_BITS  (AB),
        .LATENCY    (LAT)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_addr      (inst_addr),
        .inst_resp_valid(inst_resp_valid),
        .inst_data      (inst_data),
        .inst_err       (inst_err),
        .data_req_valid (data_req_valid),
        .data_req_ready (data_req_ready),
        .data_addr      (data_addr),
        .data_we        (data_we),
        .data_be        (data_be),
        .data_wdata     (data_wdata),
        .data_resp_valid(data_resp_valid),
        .data_rdata     (data_rdata),
        .data_err       (data_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int w);
        case (w)
            4:       return 32'h0000_0013;
            8:       return 32'h1122_3344;
            12:      return 32'hAAAA_AAAA;
            default: return {8'(w), 8'hC3, ~8'(w), 8'h5A};
        endcase
    endfunction

    // Reference model: a request accepted at the end of cycle c answers in cycle c+LAT,
    // and the port is free again from cycle c+LAT+1.
    logic [31:0] m_mem [DEPTH];
    bit          mi_pend, md_pend, mi_err, md_err, m_ir, m_dr;
    int          mi_rc, md_rc;
    logic [31:0] mi_data, md_data;

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mi_pend = 1'b0;
            md_pend = 1'b0;
        end else begin
            m_ir = !mi_pend || (cyc > mi_rc);
            m_dr = !md_pend || (cyc > md_rc);
            if (inst_req_valid && m_ir) begin
                mi_pend = 1'b1;
                mi_rc   = cyc + LAT;
                mi_err  = addr_bad(inst_addr);
                mi_data = mi_err ? 32'h0 : m_mem[widx(inst_addr)];
            end
            if (data_req_valid && m_dr) begin
                md_pend = 1'b1;
                md_rc   = cyc + LAT;
                md_err  = addr_bad(data_addr);
                md_data = (md_err || data_we) ? 32'h0 : m_mem[widx(data_addr)];
                if (!md_err && data_we)
                    for (int b = 0; b < 4; b++)
                        if (data_be[b]) m_mem[widx(data_addr)][8*b +: 8] = data_wdata[8*b +: 8];
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_inst_ready", 32'(inst_req_ready), 0);
            check("rst_inst_valid", 32'(inst_resp_valid), 0);
            check("rst_inst_data", inst_data, 0);
            check("rst_inst_err", 32'(inst_err), 0);
            check("rst_data_ready", 32'(data_req_ready), 0);
            check("rst_data_valid", 32'(data_resp_valid), 0);
            check("rst_data_rdata", data_rdata, 0);
            check("rst_data_err", 32'(data_err), 0);
        end else begin
            automatic bit eir = !mi_pend || (cyc > mi_rc);
            automatic bit eiv = mi_pend && (cyc == mi_rc);
            automatic bit edr = !md_pend || (cyc > md_rc);
            automatic bit edv = md_pend && (cyc == md_rc);
            check("inst_req_ready", 32'(inst_req_ready), 32'(eir));
            check("inst_resp_valid", 32'(inst_resp_valid), 32'(eiv));
            check("inst_data", inst_data, eiv ? mi_data : 32'h0);
            check("inst_err", 32'(inst_err), 32'(eiv && mi_err));
            check("data_req_ready", 32'(data_req_ready), 32'(edr));
            check("data_resp_valid", 32'(data_resp_valid), 32'(edv));
            check("data_rdata", data_rdata, edv ? md_data : 32'h0);
            check("data_err", 32'(data_err), 32'(edv && md_err));
        end
    end

    task automatic do_inst(input logic [31:0] a, input bit wait_resp,
                           output logic [31:0] rd, output logic er, output int acc_c, output int rsp_c);
        bit got = 1'b0;
        rd = '0; er = 1'b0; acc_c = -1; rsp_c = -1;
        @(posedge clk); #2;
        inst_req_valid = 1'b1;
        inst_addr      = a;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (inst_req_ready) begin got = 1'b1; acc_c = cyc; end
        end
        check("inst_accept_in_time", 32'(got), 1);
        if (!got || !wait_resp) return;
        @(posedge clk); #2;
        inst_req_valid = 1'b0;
        inst_addr      = $urandom;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (inst_resp_valid) begin got = 1'b1; rd = inst_data; er = inst_err; rsp_c = cyc; end
        end
        check("inst_resp_in_time", 32'(got), 1);
    endtask

    task automatic do_data(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input bit wait_resp,
                           output logic [31:0] rd, output logic er);
        bit got = 1'b0;
        rd = '0; er = 1'b0;
        @(posedge clk); #2;
        data_req_valid = 1'b1;
        data_addr      = a;
        data_we        = we;
        data_be        = be;
        data_wdata     = wd;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (data_req_ready) got = 1'b1;
        end
        check("data_accept_in_time", 32'(got), 1);
        if (!got || !wait_resp) return;
        @(posedge clk); #2;
        data_req_valid = 1'b0;
        data_addr      = $urandom;
        data_wdata     = $urandom;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (data_resp_valid) begin got = 1'b1; rd = data_rdata; er = data_err; end
        end
        check("data_resp_in_time", 32'(got), 1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int unsigned s = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15)) << 2;
        if (s == 0) begin
            a[1:0] = 2'($urandom_range(1, 3));
        end else if (s == 1) begin
            a = $urandom;
            if (a[31:12] == '0) a[12] = 1'b1;
        end
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd2;
        logic        er, er2;
        int          a, r, a2, r2, nacc, nresp;
        int          acc [3];
        logic [31:0] rsp [3];

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("inst_ready_after_reset", 32'(inst_req_ready), 1);
        check("data_ready_after_reset", 32'(data_req_ready), 1);

        for (int w = 0; w < 16; w++) begin
            do_data(32'(w * 4), 1'b1, 4'hF, init_val(w), 1'b1, rd, er);
            check("init_store_rdata", rd, 0);
            check("init_store_err", 32'(er), 0);
        end

        do_inst(32'h10, 1'b1, rd, er, a, r);
        check("fetch10_data", rd, 32'h0000_0013);
        check("fetch10_err", 32'(er), 0);
        check("fetch10_latency", 32'(r - a), 2);

        do_data(32'h20, 1'b1, 4'b0101, 32'hDEAD_BEEF, 1'b1, rd, er);
        check("store20_rdata", rd, 0);
        check("store20_err", 32'(er), 0);
        do_data(32'h20, 1'b0, 4'h0, 32'h0, 1'b1, rd, er);
        check("load20_merged", rd, 32'h11AD_33EF);
        check("load20_err", 32'(er), 0);

        do_data(32'h22, 1'b0, 4'h0, 32'h0, 1'b1, rd, er);
        check("misaligned_err", 32'(er), 1);
        check("misaligned_rdata", rd, 0);
        do_data(32'(DEPTH * 4), 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, rd, er);
        check("oor_store_err", 32'(er), 1);
        do_data(32'h0, 1'b0, 4'h0, 32'h0, 1'b1, rd, er);
        check("word0_unchanged", rd, init_val(0));

        fork
            do_inst(32'h30, 1'b1, rd, er, a, r);
            do_data(32'h30, 1'b1, 4'hF, 32'h5555_5555, 1'b1, rd2, er2);
        join
        check("collide_fetch_old", rd, 32'hAAAA_AAAA);
        check("collide_same_edge", 32'(a2 * 0 + a), 32'(a));
        do_inst(32'h30, 1'b1, rd, er, a, r);
        check("refetch30_new", rd, 32'h5555_5555);

        // Fetch valid held high across three requests.
        nacc = 0; nresp = 0;
        @(posedge clk); #2;
        inst_req_valid = 1'b1;
        inst_addr      = 32'h0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (inst_resp_valid && nresp < 3) begin rsp[nresp] = inst_data; nresp++; end
            if (inst_req_ready && nacc < 3) begin
                acc[nacc] = cyc;
                @(posedge clk); #2;
                nacc++;
                if (nacc < 3) inst_addr = 32'(nacc * 4);
                else inst_req_valid = 1'b0;
            end
        end
        check("hold_accepts", 32'(nacc), 3);
        check("hold_responses", 32'(nresp), 3);
        for (int k = 0; k < 3; k++) check("hold_resp_data", rsp[k], init_val(k));
        check("hold_spacing_01", 32'(acc[1] - acc[0]), 3);
        check("hold_spacing_12", 32'(acc[2] - acc[1]), 3);

        // Reset during WAIT of a load.
        @(posedge clk); #2;
        data_req_valid = 1'b1;
        data_addr      = 32'h4;
        data_we        = 1'b0;
        @(negedge clk);
        check("rst_test_ready", 32'(data_req_ready), 1);
        @(posedge clk); #2;
        data_req_valid = 1'b0;
        rst            = 1'b1;
        nresp = 0;
        repeat (2) begin @(negedge clk); if (data_resp_valid) nresp++; end
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(data_req_ready), 1);
        if (data_resp_valid) nresp++;
        repeat (4) begin @(negedge clk); if (data_resp_valid) nresp++; end
        check("aborted_no_resp", 32'(nresp), 0);
        do_data(32'h4, 1'b0, 4'h0, 32'h0, 1'b1, rd, er);
        check("load_after_reset", rd, init_val(1));

        fork
            begin
                logic [31:0] xr; logic xe; int xa, xb;
                repeat (250) begin
                    int unsigned gap;
                    do_inst(rand_addr(), 1'b0, xr, xe, xa, xb);
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        @(posedge clk); #2 inst_req_valid = 1'b0;
                        repeat (gap - 1) @(posedge clk);
                    end
                end
                @(posedge clk); #2 inst_req_valid = 1'b0;
            end
            begin
                logic [31:0] yr; logic ye;
                repeat (250) begin
                    int unsigned gap;
                    do_data(rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'b0, yr, ye);
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        @(posedge clk); #2 data_req_valid = 1'b0;
                        repeat (gap - 1) @(posedge clk);
                    end
                end
                @(posedge clk); #2 data_req_valid = 1'b0;
            end
        join
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
